usb_rx_decoder: RTL



---
 rtl/usb_rx_pkg.sv | 35 +++
 rtl/usb_rx_if.sv | 28 ++
 rtl/usb_rx_bit_timer.sv | 39 +++
 rtl/usb_rx_decoder.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// ==========================================================================
// usb_rx_pkg: shared types/constants for the USB full-speed receive path.
// Revision: 1.0
// ==========================================================================
`default_nettype none

package usb_rx_pkg;

  localparam int DEF_CLKS_PER_BIT = 8;
  localparam int DEF_SAMPLE_PT    = 3;
  localparam int DEF_STUFF_LEN    = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SE0_1  = 2'd2,
    WAIT_J = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    LINE_SE0 = 2'b00,
    LINE_K   = 2'b01,
    LINE_J   = 2'b10
  } line_t;

  // dp=dm=1 is illegal on the wire; it is folded into J
  function automatic line_t decode_line(input logic dp, input logic dm);
    if (dp)      return LINE_J;
    else if (dm) return LINE_K;
    else         return LINE_SE0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/usb_rx_if.sv
// ==========================================================================
// usb_rx_if: line inputs and decoded-bit outputs of the USB receive decoder.
// Revision: 1.0
// ==========================================================================
`default_nettype none

interface usb_rx_if;
  logic dp_in;
  logic dm_in;
  logic enable;
  logic d_orig;
  logic shift_enable;
  logic eop;
  logic rx_err;
  logic busy;

  modport master (
    output dp_in, dm_in, enable,
    input  d_orig, shift_enable, eop, rx_err, busy
  );

  modport slave (
    input  dp_in, dm_in, enable,
    output d_orig, shift_enable, eop, rx_err, busy
  );
endinterface

`default_nettype wire

// File: rtl/usb_rx_bit_timer.sv
// ==========================================================================
// usb_rx_bit_timer: bit-period counter with resync clear and mid-bit sample.
// Revision: 1.0
// ==========================================================================
`default_nettype none

module usb_rx_bit_timer
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int SAMPLE_PT    = DEF_SAMPLE_PT
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic run,
  output logic sample
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [TW-1:0] timer;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      timer <= '0;
    end else if (clear) begin
      timer <= '0;
    end else if (run) begin
      timer <= (timer == TW'(CLKS_PER_BIT - 1)) ? '0 : timer + 1'b1;
    end
  end

  // a resync clear outranks a sample landing on the same cycle
  assign sample = run && !clear && (timer == TW'(SAMPLE_PT));

endmodule

`default_nettype wire

// File: rtl/usb_rx_decoder.sv
// ==========================================================================
// usb_rx_decoder: USB FS receive line decoder (sync, NRZI, unstuff, EOP).
// Revision: 1.0
// ==========================================================================
`default_nettype none

module usb_rx_decoder
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int SAMPLE_PT    = DEF_SAMPLE_PT,
  parameter int STUFF_LEN    = DEF_STUFF_LEN
) (
  input  logic     clk,
  input  logic     n_rst,
  usb_rx_if.slave  bus
);

  localparam int CW = $clog2(STUFF_LEN + 1);

  logic          dp_meta, dp_s, dp_s_d;
  logic          dm_meta, dm_s;
  rx_state_t     state;
  logic          prev_bit;
  logic [CW-1:0] ones_cnt;
  logic          d_orig, shift_enable, eop, rx_err;
  logic          sample, dp_edge, timer_clear, bit_val, stuff_full;
  line_t         line;

  // idle line is J, so the synchronizer resets to dp=1, dm=0
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_meta <= 1'b1;
      dp_s    <= 1'b1;
      dp_s_d  <= 1'b1;
      dm_meta <= 1'b0;
      dm_s    <= 1'b0;
    end else begin
      dp_meta <= bus.dp_in;
      dp_s    <= dp_meta;
      dp_s_d  <= dp_s;
      dm_meta <= bus.dm_in;
      dm_s    <= dm_meta;
    end
  end

  assign line        = decode_line(dp_s, dm_s);
  assign dp_edge     = dp_s ^ dp_s_d;
  assign timer_clear = (state == IDLE) || !bus.enable || ((state == RUN) && dp_edge);
  assign bit_val     = (dp_s == prev_bit);
  assign stuff_full  = (ones_cnt == CW'(STUFF_LEN));

  usb_rx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SAMPLE_PT    (SAMPLE_PT)
  ) u_timer (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (timer_clear),
    .run    (state != IDLE),
    .sample (sample)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      prev_bit     <= 1'b1;
      ones_cnt     <= '0;
      d_orig       <= 1'b1;
      shift_enable <= 1'b0;
      eop          <= 1'b0;
      rx_err       <= 1'b0;
    end else begin
      shift_enable <= 1'b0;
      eop          <= 1'b0;
      rx_err       <= 1'b0;
      if (!bus.enable) begin
        state    <= IDLE;
        prev_bit <= 1'b1;
        ones_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (dp_edge && !dp_s) begin
              state    <= RUN;
              prev_bit <= 1'b1;
              ones_cnt <= '0;
            end
          end
          RUN: begin
            if (sample) begin
              if (line == LINE_SE0) begin
                state    <= SE0_1;
                ones_cnt <= '0;
              end else begin
                prev_bit <= dp_s;
                if (stuff_full) begin
                  // a 0 here is the stuffed bit; a 1 breaks the stuffing rule
                  ones_cnt <= '0;
                  rx_err   <= bit_val;
                end else begin
                  d_orig       <= bit_val;
                  shift_enable <= 1'b1;
                  ones_cnt     <= bit_val ? ones_cnt + 1'b1 : '0;
                end
              end
            end
          end
          SE0_1: begin
            if (sample) begin
              if (line == LINE_SE0) begin
                eop   <= 1'b1;
                state <= WAIT_J;
              end else begin
                // lone SE0: flag it, keep decoding but the error strobe wins this bit
                rx_err   <= 1'b1;
                state    <= RUN;
                prev_bit <= dp_s;
                ones_cnt <= bit_val ? ones_cnt + 1'b1 : '0;
              end
            end
          end
          WAIT_J: begin
            if (sample && (line == LINE_J)) begin
              state    <= IDLE;
              prev_bit <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.d_orig       = d_orig;
  assign bus.shift_enable = shift_enable;
  assign bus.eop          = eop;
  assign bus.rx_err       = rx_err;
  assign bus.busy         = (state != IDLE);

endmodule

`default_nettype wire
